// File: rtl/peripheral_mpram_wb_burst_master.sv
// Wishbone B3 burst master driving the single-port RAM slave.
// Turns a command channel plus write/read data streams into classic or
// incrementing-burst cycles with per-beat CTI/BTE.
// Optional watchdog: define PERIPHERAL_MPRAM_WB_TIMEOUT_EN to abort a cycle
// after TIMEOUT cycles without ack.
module peripheral_mpram_wb_burst_master #(
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 8,
  parameter int unsigned LW      = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic            cmd_we_i,
  input  logic [AW-1:0]   cmd_adr_i,
  input  logic [LW-1:0]   cmd_len_i,
  input  logic [1:0]      cmd_bte_i,
  input  logic            wdat_valid_i,
  output logic            wdat_ready_o,
  input  logic [DW-1:0]   wdat_i,
  input  logic [DW/8-1:0] wsel_i,
  output logic            rdat_valid_o,
  output logic [DW-1:0]   rdat_o,
  output logic            rdat_last_o,
  output logic            done_o,
  output logic            err_o,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic            wb_we_o,
  output logic [1:0]      wb_bte_o,
  output logic [2:0]      wb_cti_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack_i,
  input  logic            wb_err_i
);

  localparam int unsigned SH = (DW == 64) ? 3 : 2;
  localparam int unsigned BW = AW - SH;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  typedef enum logic [1:0] {IDLE, WAIT_DATA, BUS} state_t;

  state_t            state_q, state_d;
  logic [LW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     adr_d;
  logic [DW-1:0]     dat_d, rdat_d;
  logic [DW/8-1:0]   sel_d;
  logic              we_d, bus_d, cmd_ready_d;
  logic [1:0]        bte_d;
  logic [2:0]        cti_d;
  logic              rdat_valid_d, rdat_last_d, done_d, err_d;
  logic              tmo_abort, bus_abort, beat_ok;

  // Next beat address: advance in beat units, wrapping inside the burst window
  function automatic logic [AW-1:0] next_adr(input logic [AW-1:0] a, input logic [1:0] bte);
    logic [BW-1:0] b, inc, mask;
    b   = a[AW-1:SH];
    inc = b + BW'(1);
    case (bte)
      2'd1:    mask = BW'(3);
      2'd2:    mask = BW'(7);
      2'd3:    mask = BW'(15);
      default: mask = '1;
    endcase
    b = (b & ~mask) | (inc & mask);
    return {b, a[SH-1:0]};
  endfunction

`ifdef PERIPHERAL_MPRAM_WB_TIMEOUT_EN
  localparam int unsigned TCW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [TCW-1:0] tmo_q;

  // Watchdog: cycles in BUS since entry or the most recent ack
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i || state_q != BUS || wb_ack_i) tmo_q <= '0;
    else                                         tmo_q <= tmo_q + TCW'(1);
  end

  assign tmo_abort = (state_q == BUS) && !wb_ack_i && (tmo_q == TCW'(TIMEOUT - 1));
`else
  assign tmo_abort = 1'b0;
`endif

  assign bus_abort = (state_q == BUS) && (wb_err_i || tmo_abort);
  assign beat_ok   = (state_q == BUS) && wb_ack_i && !wb_err_i;

  // Write data is taken while waiting, or on an acked non-final write beat
  assign wdat_ready_o = wb_rst_i &&
                        ((state_q == WAIT_DATA) ||
                         (beat_ok && wb_we_o && (cnt_q != '0)));

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    adr_d        = wb_adr_o;
    dat_d        = wb_dat_o;
    sel_d        = wb_sel_o;
    we_d         = wb_we_o;
    bte_d        = wb_bte_o;
    cti_d        = wb_cti_o;
    bus_d        = wb_cyc_o;
    rdat_d       = rdat_o;
    rdat_valid_d = 1'b0;
    rdat_last_d  = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          we_d  = cmd_we_i;
          adr_d = cmd_adr_i;
          cnt_d = cmd_len_i;
          if (cmd_len_i == '0) begin
            bte_d = 2'b00;
            cti_d = CTI_CLASSIC;
          end else begin
            bte_d = cmd_bte_i;
            cti_d = CTI_INCR;
          end
          if (cmd_we_i) begin
            state_d = WAIT_DATA;
          end else begin
            state_d = BUS;
            bus_d   = 1'b1;
            sel_d   = '1;
          end
        end
      end
      WAIT_DATA: begin
        if (wdat_valid_i) begin
          dat_d   = wdat_i;
          sel_d   = wsel_i;
          bus_d   = 1'b1;
          state_d = BUS;
        end
      end
      BUS: begin
        if (bus_abort) begin
          bus_d   = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (wb_ack_i) begin
          if (!wb_we_o) begin
            rdat_valid_d = 1'b1;
            rdat_d       = wb_dat_i;
            rdat_last_d  = (cnt_q == '0);
          end
          if (cnt_q == '0) begin
            done_d  = 1'b1;
            bus_d   = 1'b0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - LW'(1);
            adr_d = next_adr(wb_adr_o, wb_bte_o);
            cti_d = (cnt_q == LW'(1)) ? CTI_END : CTI_INCR;
            if (wb_we_o) begin
              if (wdat_valid_i) begin
                dat_d = wdat_i;
                sel_d = wsel_i;
              end else begin
                bus_d   = 1'b0;
                state_d = WAIT_DATA;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    cmd_ready_d = (state_d == IDLE);
  end

  // State and registered outputs
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cmd_ready_o  <= 1'b0;
      rdat_valid_o <= 1'b0;
      rdat_o       <= '0;
      rdat_last_o  <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      wb_adr_o     <= '0;
      wb_dat_o     <= '0;
      wb_sel_o     <= '0;
      wb_we_o      <= 1'b0;
      wb_bte_o     <= 2'b00;
      wb_cti_o     <= 3'b000;
      wb_cyc_o     <= 1'b0;
      wb_stb_o     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cmd_ready_o  <= cmd_ready_d;
      rdat_valid_o <= rdat_valid_d;
      rdat_o       <= rdat_d;
      rdat_last_o  <= rdat_last_d;
      done_o       <= done_d;
      err_o        <= err_d;
      wb_adr_o     <= adr_d;
      wb_dat_o     <= dat_d;
      wb_sel_o     <= sel_d;
      wb_we_o      <= we_d;
      wb_bte_o     <= bte_d;
      wb_cti_o     <= cti_d;
      wb_cyc_o     <= bus_d;
      wb_stb_o     <= bus_d;
    end
  end

endmodule

// File: tb/tb_peripheral_mpram_wb_burst_master.sv
// Scoreboard bench for peripheral_mpram_wb_burst_master with a RAM slave model.
module tb_peripheral_mpram_wb_burst_master;

  localparam int NW = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready_o, cmd_we;
  logic [7:0]  cmd_adr;
  logic [3:0]  cmd_len;
  logic [1:0]  cmd_bte;
  logic        wdat_valid, wdat_ready_o;
  logic [31:0] wdat;
  logic [3:0]  wsel;
  logic        rdat_valid_o, rdat_last_o, done_o, err_o;
  logic [31:0] rdat_o;
  logic [7:0]  wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic [1:0]  wb_bte_o;
  logic [2:0]  wb_cti_o;
  logic [31:0] wb_dat_in;
  logic        wb_ack, wb_err;

  always #5 clk = ~clk;

  peripheral_mpram_wb_burst_master #(.DW(32), .AW(8), .LW(4), .TIMEOUT(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_len_i(cmd_len), .cmd_bte_i(cmd_bte),
    .wdat_valid_i(wdat_valid), .wdat_ready_o(wdat_ready_o), .wdat_i(wdat), .wsel_i(wsel),
    .rdat_valid_o(rdat_valid_o), .rdat_o(rdat_o), .rdat_last_o(rdat_last_o),
    .done_o(done_o), .err_o(err_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_bte_o(wb_bte_o), .wb_cti_o(wb_cti_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_dat_i(wb_dat_in), .wb_ack_i(wb_ack), .wb_err_i(wb_err)
  );

  logic [89:0] all_outs;
  assign all_outs = {cmd_ready_o, wdat_ready_o, rdat_valid_o, rdat_o, rdat_last_o, done_o, err_o,
                     wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_bte_o, wb_cti_o, wb_cyc_o, wb_stb_o};

  typedef struct {
    logic [7:0]  adr;
    logic        we;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] dat;
    logic [3:0]  sel;
  } beat_t;

  typedef struct {
    logic [31:0] dat;
    logic        last;
  } rd_t;

  beat_t       exp_bus[$];
  rd_t         exp_rd[$];
  bit          exp_evt[$];
  logic [31:0] ref_mem[NW];
  logic [31:0] slave_mem[NW];
  int          n_tests = 0, n_fail = 0;
  int          evt_seen = 0;
  int          beat_idx = 0;
  int          cur_err_at = -1;
  bit          no_ack = 1'b0, fast = 1'b0, gap_check = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Word index of beat k: linear modulo memory, or wrap inside an aligned 4/8/16 window
  function automatic int exp_word(input int start_w, input int bte, input int k);
    int n;
    if (bte == 0) return (start_w + k) % NW;
    n = 4 << (bte - 1);
    return (start_w / n) * n + ((start_w + k) % n);
  endfunction

  // Slave: random ack/err at negedge, bus-beat monitor, RAM update
  initial begin : slave
    beat_t e;
    wb_ack = 1'b0; wb_err = 1'b0; wb_dat_in = '0;
    forever begin
      @(negedge clk);
      if (wb_cyc_o && wb_stb_o) begin
        wb_dat_in = slave_mem[wb_adr_o[7:2]];
        if (no_ack) begin
          wb_ack = 1'b0; wb_err = 1'b0;
        end else if (beat_idx == cur_err_at) begin
          wb_err = 1'b1; wb_ack = 1'($urandom_range(0, 1));
        end else begin
          wb_err = 1'b0; wb_ack = fast ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
        if (wb_ack && !wb_err) begin
          if (exp_bus.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL bus_extra: got beat at adr 0x%0h expected no beat", wb_adr_o);
          end else begin
            e = exp_bus.pop_front();
            check("bus_adr", 64'(wb_adr_o), 64'(e.adr));
            check("bus_we",  64'(wb_we_o),  64'(e.we));
            check("bus_cti", 64'(wb_cti_o), 64'(e.cti));
            check("bus_bte", 64'(wb_bte_o), 64'(e.bte));
            if (e.we) begin
              check("bus_dat", 64'(wb_dat_o), 64'(e.dat));
              check("bus_sel", 64'(wb_sel_o), 64'(e.sel));
            end
          end
          if (wb_we_o) slave_mem[wb_adr_o[7:2]] = merge(slave_mem[wb_adr_o[7:2]], wb_dat_o, wb_sel_o);
          beat_idx++;
        end
      end else begin
        wb_ack = 1'b0; wb_err = 1'b0; wb_dat_in = $urandom;
      end
      #2;
      if (cmd_valid && cmd_ready_o) beat_idx = 0;
    end
  end

  // Read-data and completion monitor
  initial begin : monitor
    rd_t r;
    bit  ev;
    forever begin
      @(negedge clk);
      if (rdat_valid_o) begin
        if (exp_rd.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL rd_extra: got rdat 0x%0h expected none", rdat_o);
        end else begin
          r = exp_rd.pop_front();
          check("rdat", 64'(rdat_o), 64'(r.dat));
          check("rdat_last", 64'(rdat_last_o), 64'(r.last));
        end
      end
      if (done_o || err_o) begin
        if (exp_evt.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL evt_extra: got done=%0b err=%0b expected none", done_o, err_o);
        end else begin
          ev = exp_evt.pop_front();
          check("evt_done_err", 64'({done_o, err_o}), ev ? 64'h1 : 64'h2);
        end
        check("cyc_after_end", 64'(wb_cyc_o), 64'h0);
        check("ready_after_end", 64'(cmd_ready_o), 64'h1);
        evt_seen++;
      end
    end
  end

  task automatic issue_cmd(input bit we, input int adr, input int len, input int bte);
    int tries;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = 8'(adr); cmd_len = 4'(len); cmd_bte = 2'(bte);
    tries = 0;
    while (!cmd_ready_o && tries < 50) begin @(negedge clk); tries++; end
    check("cmd_accept_in_time", 64'(tries < 50), 64'h1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_cmd(input bit we, input int adr, input int len, input int bte, input int err_at,
                         input int stall_beat, input int stall_cycles, input bit seq_data);
    logic [31:0] wd[16];
    logic [3:0]  ws[16];
    int          start_w, nok, nfeed, w, tries, ev0;
    beat_t       e;
    rd_t         r;
    start_w = adr / 4;
    nok     = (err_at >= 0) ? err_at : len + 1;
    nfeed   = we ? ((err_at >= 0) ? err_at + 1 : len + 1) : 0;
    for (int k = 0; k < 16; k++) begin
      wd[k] = seq_data ? 32'(k + 1) : $urandom;
      ws[k] = seq_data ? 4'hF : 4'($urandom_range(1, 15));
    end
    for (int k = 0; k < nok; k++) begin
      w     = exp_word(start_w, bte, k);
      e.adr = 8'(w * 4);
      e.we  = we;
      e.cti = (len == 0) ? 3'b000 : ((k == len) ? 3'b111 : 3'b010);
      e.bte = (len == 0) ? 2'b00 : 2'(bte);
      e.dat = wd[k];
      e.sel = ws[k];
      exp_bus.push_back(e);
      if (we) ref_mem[w] = merge(ref_mem[w], wd[k], ws[k]);
      else begin
        r.dat = ref_mem[w]; r.last = (k == len);
        exp_rd.push_back(r);
      end
    end
    exp_evt.push_back(err_at >= 0);
    ev0 = evt_seen;
    cur_err_at = err_at;
    issue_cmd(we, adr, len, bte);
    for (int k = 0; k < nfeed; k++) begin
      if (k == stall_beat) begin
        wdat_valid = 1'b0;
        for (int s = 0; s < stall_cycles; s++) begin
          if (s > 0 && gap_check) begin
            #1;
            check("gap_stb", 64'(wb_stb_o), 64'h0);
            check("gap_cyc", 64'(wb_cyc_o), 64'h0);
            check("gap_adr", 64'(wb_adr_o), 64'(exp_word(start_w, bte, k) * 4));
          end
          @(negedge clk);
        end
      end
      wdat_valid = 1'b1; wdat = wd[k]; wsel = ws[k];
      tries = 0;
      #1;
      while (!wdat_ready_o && tries < 200) begin @(negedge clk); #1; tries++; end
      check("wdat_taken_in_time", 64'(tries < 200), 64'h1);
      @(negedge clk);
    end
    wdat_valid = 1'b0;
    tries = 0;
    while (evt_seen == ev0 && tries < 400) begin @(negedge clk); tries++; end
    check("cmd_end_in_time", 64'(tries < 400), 64'h1);
    repeat (2) @(negedge clk);
  endtask

  initial begin : main
    int  t, tries, len, err_at;
    bit  we;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_len = '0; cmd_bte = '0;
    wdat_valid = 1'b0; wdat = '0; wsel = '0;
    for (int i = 0; i < NW; i++) begin
      ref_mem[i]   = $urandom;
      slave_mem[i] = ref_mem[i];
    end
    ref_mem[4] = 32'hDEADBEEF; slave_mem[4] = 32'hDEADBEEF;

    repeat (3) @(negedge clk);
    check("reset_outputs_nonzero_bits", 64'($countones(all_outs)), 64'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("ready_after_reset", 64'(cmd_ready_o), 64'h1);

    // Directed scenarios
    run_cmd(1'b0, 'h10, 0, 0, -1, -1, 0, 1'b0);
    fast = 1'b1;
    run_cmd(1'b1, 'h20, 3, 0, -1, -1, 0, 1'b1);
    fast = 1'b0;
    run_cmd(1'b0, 'h0C, 3, 1, -1, -1, 0, 1'b0);
    fast = 1'b1; gap_check = 1'b1;
    run_cmd(1'b1, 'h20, 2, 0, -1, 1, 4, 1'b0);
    gap_check = 1'b0; fast = 1'b0;
    run_cmd(1'b0, 'h30, 3, 0, 1, -1, 0, 1'b0);
    run_cmd(1'b1, 'h80, 7, 2, 3, 2, 2, 1'b0);

    // Randomized commands
    for (int i = 0; i < 60; i++) begin
      we     = 1'($urandom_range(0, 1));
      len    = int'($urandom_range(0, 15));
      err_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, len)) : -1;
      fast   = 1'($urandom_range(0, 1));
      run_cmd(we, int'($urandom_range(0, 63)) * 4, len, int'($urandom_range(0, 3)), err_at,
              int'($urandom_range(0, len)), int'($urandom_range(0, 3)), 1'b0);
    end
    fast = 1'b0;

    // Reset in the middle of a stalled burst
    cur_err_at = -1; no_ack = 1'b1;
    issue_cmd(1'b0, 'h40, 7, 0);
    repeat (3) @(negedge clk);
    check("midburst_stb", 64'(wb_stb_o), 64'h1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midburst_reset_outputs_nonzero_bits", 64'($countones(all_outs)), 64'h0);
    rst_n = 1'b1; no_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("ready_after_midburst_reset", 64'(cmd_ready_o), 64'h1);

`ifdef PERIPHERAL_MPRAM_WB_TIMEOUT_EN
    // Slave never acks: abort TIMEOUT cycles after stb rises
    no_ack = 1'b1;
    exp_evt.push_back(1'b1);
    issue_cmd(1'b0, 'h08, 0, 0);
    tries = 0;
    while (!wb_stb_o && tries < 20) begin @(negedge clk); tries++; end
    t = 0;
    while (!err_o && t < 40) begin @(negedge clk); t++; end
    check("timeout_cycles", 64'(t), 64'd8);
    no_ack = 1'b0;
    repeat (2) @(negedge clk);
`endif

    check("bus_queue_drained", 64'(exp_bus.size()), 64'h0);
    check("rd_queue_drained",  64'(exp_rd.size()),  64'h0);
    check("evt_queue_drained", 64'(exp_evt.size()), 64'h0);
    for (int i = 0; i < NW; i++) check("ram_word", 64'(slave_mem[i]), 64'(ref_mem[i]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
